// File: rtl/ann_pkg.sv
// Shared types for the ANN SRAM read-port arbiter.
package ann_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Requester indices into grant / valid / done vectors.
  localparam int REQ_IMG  = 0;
  localparam int REQ_COEF = 1;

endpackage

// File: rtl/arb_burst_addr_gen.sv
// Burst address generator: latches base/length at grant, counts words,
// produces the wrapping word address and a last-word flag.
module arb_burst_addr_gen #(
  parameter int ADDR_W  = 16,
  parameter int BURST_W = 7
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [BURST_W-1:0] start_len,
  input  logic               step,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  // Load on grant, advance one word per accepted read; address wraps naturally.
  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = start_addr;
      len_d  = start_len;
      cnt_d  = '0;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q + BURST_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  // Only meaningful while reading, where len is never zero.
  assign last = (cnt_q == len_q - BURST_W'(1));

endmodule

// File: rtl/ann_sram_arbiter.sv
// Round-robin arbiter sharing the SRAM read port between the image loader
// and the ANN coefficient fetch. One burst per IDLE->READ->DONE pass.
// Optional feature: define ARB_TIMEOUT_EN to abort a burst whose ack does
// not arrive within TIMEOUT_CYC cycles (err + done pulse).
module ann_sram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 7
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               img_req,
  input  logic [ADDR_W-1:0]  img_addr,
  input  logic [BURST_W-1:0] img_len,
  input  logic               coef_req,
  input  logic [ADDR_W-1:0]  coef_addr,
  input  logic [BURST_W-1:0] coef_len,
  output logic               sram_rd_en,
  output logic [ADDR_W-1:0]  sram_addr,
  input  logic [DATA_W-1:0]  sram_rdata,
  input  logic               sram_ack,
  output logic [DATA_W-1:0]  rd_data,
  output logic               img_valid,
  output logic               coef_valid,
  output logic               img_done,
  output logic               coef_done,
  output logic [1:0]         grant,
  output logic               err
);
  import ann_pkg::*;

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic              owner_q, owner_d;   // 0 = image, 1 = coefficient
  logic              last_q, last_d;     // owner of the previous burst
  logic              load, step, last;
  logic              sel_coef;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BURST_W-1:0] sel_len;

`ifdef ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // On a tie the requester that did not own the previous burst wins.
  assign sel_coef = coef_req && (!img_req || (last_q == 1'(REQ_IMG)));
  assign sel_addr = sel_coef ? coef_addr : img_addr;
  assign sel_len  = sel_coef ? coef_len  : img_len;

  arb_burst_addr_gen #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .start_addr (sel_addr),
    .start_len  (sel_len),
    .step       (step),
    .addr       (sram_addr),
    .last       (last)
  );

  // Next-state and registered-output logic for the burst FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rd_en_d   = rd_en_q;
    rd_data_d = rd_data_q;
    valid_d   = '0;
    done_d    = '0;
    err_d     = 1'b0;
    owner_d   = owner_q;
    last_d    = last_q;
    load      = 1'b0;
    step      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (img_req || coef_req) begin
          load    = 1'b1;
          owner_d = sel_coef;
`ifdef ARB_TIMEOUT_EN
          wait_d  = '0;
`endif
          if (sel_len == '0) begin
            // Empty burst: finish without touching the SRAM.
            state_d          = DONE;
            done_d[sel_coef] = 1'b1;
          end else begin
            state_d           = READ;
            grant_d[sel_coef] = 1'b1;
            rd_en_d           = 1'b1;
          end
        end
      end
      READ: begin
        if (sram_ack) begin
          step             = 1'b1;
          rd_data_d        = sram_rdata;
          valid_d[owner_q] = 1'b1;
`ifdef ARB_TIMEOUT_EN
          wait_d           = '0;
`endif
          if (last) begin
            // Done pulse lands with the last valid.
            state_d         = DONE;
            grant_d         = '0;
            rd_en_d         = 1'b0;
            done_d[owner_q] = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          state_d         = DONE;
          grant_d         = '0;
          rd_en_d         = 1'b0;
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs; reset aborts any burst silently.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'(REQ_COEF);
`ifdef ARB_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
      wait_q    <= wait_d;
`endif
    end
  end

  assign sram_rd_en = rd_en_q;
  assign rd_data    = rd_data_q;
  assign img_valid  = valid_q[REQ_IMG];
  assign coef_valid = valid_q[REQ_COEF];
  assign img_done   = done_q[REQ_IMG];
  assign coef_done  = done_q[REQ_COEF];
  assign grant      = grant_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ann_sram_arbiter.sv
// Self-checking bench for ann_sram_arbiter: directed cases plus randomized
// request/ack traffic checked against a burst-level round-robin model.
module tb_ann_sram_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 7;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               img_req, coef_req;
  logic [ADDR_W-1:0]  img_addr, coef_addr;
  logic [BURST_W-1:0] img_len, coef_len;
  logic               sram_rd_en;
  logic [ADDR_W-1:0]  sram_addr;
  logic [DATA_W-1:0]  sram_rdata;
  logic               sram_ack;
  logic [DATA_W-1:0]  rd_data;
  logic               img_valid, coef_valid, img_done, coef_done, err;
  logic [1:0]         grant;

  int n_tests = 0;
  int n_fail  = 0;
  int last_owner;   // 0 image, 1 coef: owner of the previous burst

  always #5 clk = ~clk;

  ann_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .img_req(img_req), .img_addr(img_addr), .img_len(img_len),
    .coef_req(coef_req), .coef_addr(coef_addr), .coef_len(coef_len),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .rd_data(rd_data), .img_valid(img_valid), .coef_valid(coef_valid),
    .img_done(img_done), .coef_done(coef_done), .grant(grant), .err(err)
  );

  // SRAM contents as a function of address.
  function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
    return (a * 16'd3) ^ 16'h5A3C;
  endfunction

  assign sram_rdata = mem(sram_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rden"},  32'(sram_rd_en), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_valid"}, 32'({img_valid, coef_valid}), 0);
    chk({tag, "_done"},  32'({img_done, coef_done}), 0);
    chk({tag, "_err"},   32'(err), 0);
  endtask

  // One idle cycle between DONE and the next grant decision.
  task automatic gap();
    @(negedge clk);
    chk_quiet("gap");
  endtask

  // Follows one burst from its grant edge to the DONE cycle.
  // ack_mode: 0 random, 1 every cycle, 2 every second cycle.
  task automatic serve(input int own, input logic [ADDR_W-1:0] a0, input int len,
                       input int ack_mode, input bit drop_mid);
    int k = 0;
    int miss = 0;
    int cyc = 0;
    bit acked;
    logic [ADDR_W-1:0] ea;
    logic [1:0] g1h, v2;
    g1h = (own == 0) ? 2'b01 : 2'b10;
    v2  = (own == 0) ? 2'b10 : 2'b01;   // {img, coef}
    @(negedge clk);
    // Start address/length are latched at grant; change the inputs now.
    if (own == 0) begin img_addr = 16'($urandom); img_len = 7'($urandom); end
    else          begin coef_addr = 16'($urandom); coef_len = 7'($urandom); end
    if (len == 0) begin
      chk("zlen_done",  32'({img_done, coef_done}), 32'(v2));
      chk("zlen_rden",  32'(sram_rd_en), 0);
      chk("zlen_grant", 32'(grant), 0);
      chk("zlen_valid", 32'({img_valid, coef_valid}), 0);
    end else begin
      while (k < len) begin
        ea = a0 + k[ADDR_W-1:0];
        chk("rd_en", 32'(sram_rd_en), 1);
        chk("addr",  32'(sram_addr), 32'(ea));
        chk("grant", 32'(grant), 32'(g1h));
        chk("err",   32'(err), 0);
        if (drop_mid && k == 0) begin
          if (own == 0) img_req = 1'b0; else coef_req = 1'b0;
        end
        case (ack_mode)
          1:       acked = 1'b1;
          2:       acked = cyc[0];
          default: acked = (miss >= 3) || ($urandom_range(0, 99) < 60);
        endcase
        sram_ack = acked;
        cyc++;
        @(negedge clk);
        sram_ack = 1'b0;
        if (acked) begin
          chk("valid", 32'({img_valid, coef_valid}), 32'(v2));
          chk("rdata", 32'(rd_data), 32'(mem(ea)));
          k++;
          miss = 0;
          if (k == len) begin
            chk("done",      32'({img_done, coef_done}), 32'(v2));
            chk("rden_drop", 32'(sram_rd_en), 0);
            chk("grant_clr", 32'(grant), 0);
          end else begin
            chk("no_done", 32'({img_done, coef_done}), 0);
          end
        end else begin
          chk("no_valid", 32'({img_valid, coef_valid}), 0);
          miss++;
        end
      end
    end
    chk("done_err", 32'(err), 0);
    if (own == 0) img_req = 1'b0; else coef_req = 1'b0;
    last_owner = own;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat, win, los, wl, ll;
    bit dm;
    logic [ADDR_W-1:0] wa, la;
    n_rst = 1'b0; sram_ack = 1'b0;
    img_req = 1'b1; coef_req = 1'b1;
    img_addr = 16'h0040; img_len = 7'd2;
    coef_addr = 16'h0200; coef_len = 7'd1;
    last_owner = 1;

    // Reset with both requesting: everything quiet.
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    n_rst = 1'b1;
    serve(0, 16'h0040, 2, 0, 1'b0);   // image wins first tie
    gap();
    serve(1, 16'h0200, 1, 0, 1'b0);
    gap();

    // Four-word image burst, ack every cycle.
    img_req = 1'b1; img_addr = 16'h0100; img_len = 7'd4;
    serve(0, 16'h0100, 4, 1, 1'b0);
    gap();

    // Tie: previous owner was image, so coef goes first; image re-requests
    // during coef's turn and is then served.
    img_req = 1'b1; img_addr = 16'h0300; img_len = 7'd2;
    coef_req = 1'b1; coef_addr = 16'h0400; coef_len = 7'd2;
    serve(1, 16'h0400, 2, 0, 1'b0);
    gap();
    serve(0, 16'h0300, 2, 0, 1'b0);
    // Both together again, and image re-raises right after its burst.
    coef_req = 1'b1; coef_addr = 16'h0500; coef_len = 7'd2;
    img_req = 1'b1;  img_addr = 16'h0600; img_len = 7'd2;
    gap();
    serve(1, 16'h0500, 2, 0, 1'b0);
    img_req = 1'b1; img_addr = 16'h0600; img_len = 7'd2;
    gap();
    serve(0, 16'h0600, 2, 0, 1'b0);
    img_req = 1'b1; img_addr = 16'h0700; img_len = 7'd2;
    coef_req = 1'b1; coef_addr = 16'h0800; coef_len = 7'd2;
    gap();
    serve(1, 16'h0800, 2, 0, 1'b0);
    gap();
    serve(0, 16'h0700, 2, 0, 1'b0);
    gap();

    // Zero-length coefficient burst never strobes the SRAM.
    coef_req = 1'b1; coef_addr = 16'h1234; coef_len = 7'd0;
    serve(1, 16'h1234, 0, 0, 1'b0);
    gap();

    // Address wrap with ack every second cycle.
    img_req = 1'b1; img_addr = 16'hFFFE; img_len = 7'd3;
    serve(0, 16'hFFFE, 3, 2, 1'b0);
    gap();

    // Async reset mid-burst: outputs drop at once, no done afterwards.
    img_req = 1'b1; img_addr = 16'h2000; img_len = 7'd5;
    @(negedge clk);
    chk("mid_grant", 32'(grant), 2'b01);
    sram_ack = 1'b1;
    @(negedge clk);
    sram_ack = 1'b0;
    chk("mid_valid", 32'(img_valid), 1);
    #2 n_rst = 1'b0;
    #1 chk_quiet("mid_rst");
    img_req = 1'b0;
    @(negedge clk);
    chk_quiet("mid_rst_hold");
    n_rst = 1'b1;
    last_owner = 1;
    @(negedge clk);
    chk_quiet("post_rst");

`ifdef ARB_TIMEOUT_EN
    begin
      int n = 0;
      img_req = 1'b1; img_addr = 16'h3000; img_len = 7'd3;
      @(negedge clk);
      while (sram_rd_en && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("to_cycles", 32'(n), 16);
      chk("to_err",    32'(err), 1);
      chk("to_done",   32'(img_done), 1);
      img_req = 1'b0;
      last_owner = 0;
      gap();
    end
`endif

    // Randomized traffic against the burst-level round-robin model.
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(0, 2);    // 0 image, 1 coef, 2 both
      img_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
      coef_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      img_len   = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
      coef_len  = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
      img_req   = (pat != 1);
      coef_req  = (pat != 0);
      if (pat == 2) win = (last_owner == 0) ? 1 : 0;
      else          win = pat;
      los = 1 - win;
      wa = (win == 0) ? img_addr : coef_addr;
      wl = (win == 0) ? int'(img_len) : int'(coef_len);
      la = (los == 0) ? img_addr : coef_addr;
      ll = (los == 0) ? int'(img_len) : int'(coef_len);
      dm = ($urandom_range(0, 3) == 0);
      serve(win, wa, wl, 0, dm);
      gap();
      if (pat == 2) begin
        serve(los, la, ll, 0, 1'b0);
        gap();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
